wb_pcg_rng_multi: RTL and testbench

WB_PCG_RNG_MULTI -- requirements
Module: wb_pcg_rng_multi

---
 rtl/wb_pcg_rng_multi.sv | 172 +++++++++++++++++
 tb/tb_wb_pcg_rng_multi.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pcg_rng_multi.sv
// Wishbone-attached bank of independent 64-bit LCG generators. Each channel
// has its own seed/multiplier/increment, emits 32-bit words through a
// PCG-style output function, and buffers them in a small FIFO popped by
// reads of the DATA register.
module wb_pcg_rng_multi #(
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int MODE_DEFAULT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] dat_w,
    output logic [31:0] dat_r,
    input  logic        sel,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = PW + 1;
    localparam logic [63:0] SEED_RST = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] MULT_RST = 64'h5851_F42D_4C95_7F2D;
    localparam logic [63:0] INC_RST  = 64'h1405_7B7E_F767_814F;
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic MODE_RST = 1'(MODE_DEFAULT);

    logic        ack_q, done_q;
    logic [31:0] dat_r_q, rd_mux;
    logic        req, addr_ok;
    logic [2:0]  ch_a, reg_a;
    logic [CHANNELS-1:0][31:0] rd_word;
    logic        unused_sel;

    // Byte lanes are not supported; every access is a full word.
    assign unused_sel = sel;
    assign ch_a  = adr[5:3];
    assign reg_a = adr[2:0];
    // done_q blocks a second acknowledge while the master keeps stb high.
    assign req     = cyc & stb & ~done_q;
    assign addr_ok = (adr[31:6] == 26'd0) && (int'(ch_a) < CHANNELS);

    // Select the addressed channel's read word; unmapped addresses read 0.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (addr_ok && (ch_a == 3'(c))) rd_mux = rd_word[c];
        end
    end

    // Bus handshake: one registered ack per access, data zero outside ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            dat_r_q <= '0;
        end else begin
            ack_q   <= req;
            done_q  <= cyc & stb;
            dat_r_q <= (req && !we) ? rd_mux : '0;
        end
    end

    assign ack   = ack_q;
    assign dat_r = dat_r_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [63:0]   seed_q, mult_q, inc_q, state_q, state_d;
        logic          en_q, mode_q, uf_q;
        logic [31:0]   fifo_q [FIFO_DEPTH];
        logic [PW-1:0] wptr_q, rptr_q;
        logic [LW-1:0] level_q, level_d;
        logic          sel_c, wr_c, rd_c, pop, push, reseed, uflow, clr_uf;
        logic [31:0]   x, out_w, status_w, ch_rd;
        logic [4:0]    rot;

        assign sel_c  = req & addr_ok & (ch_a == 3'(c));
        assign wr_c   = sel_c & we;
        assign rd_c   = sel_c & ~we;
        assign pop    = rd_c & (reg_a == 3'd0) & (level_q != '0);
        assign uflow  = rd_c & (reg_a == 3'd0) & (level_q == '0);
        assign reseed = wr_c & (reg_a == 3'd7) & dat_w[2];
        assign clr_uf = wr_c & (reg_a == 3'd7) & dat_w[3];
        // A pop frees a slot in the same cycle, so a full FIFO keeps streaming.
        assign push    = en_q & ((level_q < LVL_FULL) | pop) & ~reseed;
        assign level_d = level_q + LW'(push) - LW'(pop);
        assign state_d = push ? (state_q * mult_q + inc_q) : state_q;

        // Output permutation of the current state (xorshift-low or XSH-RR).
        always_comb begin
            x     = 32'((state_q ^ (state_q >> 18)) >> 27);
            rot   = state_q[63:59];
            out_w = mode_q ? ((x >> rot) | (x << (6'd32 - {1'b0, rot})))
                           : (state_q[31:0] ^ {18'b0, state_q[63:50]});
        end

        // Status word and per-register read data for this channel.
        always_comb begin
            status_w         = '0;
            status_w[0]      = en_q;
            status_w[1]      = mode_q;
            status_w[8 +: LW] = level_q;
            status_w[16]     = (level_q == '0);
            status_w[17]     = (level_q == LVL_FULL);
            status_w[18]     = uf_q;
            ch_rd = '0;
            case (reg_a)
                3'd0: ch_rd = (level_q != '0) ? fifo_q[rptr_q] : '0;
                3'd1: ch_rd = seed_q[63:32];
                3'd2: ch_rd = seed_q[31:0];
                3'd3: ch_rd = mult_q[63:32];
                3'd4: ch_rd = mult_q[31:0];
                3'd5: ch_rd = inc_q[63:32];
                3'd6: ch_rd = inc_q[31:0];
                default: ch_rd = status_w;
            endcase
        end
        assign rd_word[c] = ch_rd;

        // FIFO storage; contents are don't-care until the level covers them.
        always_ff @(posedge clk) begin
            if (push) fifo_q[wptr_q] <= out_w;
        end

        // Configuration registers, generator state and FIFO bookkeeping.
        always_ff @(posedge clk) begin
            if (rst) begin
                seed_q  <= SEED_RST;
                mult_q  <= MULT_RST;
                inc_q   <= INC_RST + 64'(2 * c);
                state_q <= SEED_RST;
                en_q    <= 1'b0;
                mode_q  <= MODE_RST;
                uf_q    <= 1'b0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                level_q <= '0;
            end else begin
                if (wr_c) begin
                    case (reg_a)
                        3'd1: seed_q[63:32] <= dat_w;
                        3'd2: seed_q[31:0]  <= dat_w;
                        3'd3: mult_q[63:32] <= dat_w;
                        3'd4: mult_q[31:0]  <= dat_w;
                        3'd5: inc_q[63:32]  <= dat_w;
                        3'd6: inc_q[31:0]   <= dat_w;
                        3'd7: begin
                            en_q   <= dat_w[0];
                            mode_q <= dat_w[1];
                        end
                        default: ;
                    endcase
                end
                if (clr_uf) uf_q <= 1'b0;
                else if (uflow) uf_q <= 1'b1;
                if (reseed) begin
                    state_q <= seed_q;
                    wptr_q  <= '0;
                    rptr_q  <= '0;
                    level_q <= '0;
                end else begin
                    if (push) wptr_q <= wptr_q + PW'(1);
                    if (pop) rptr_q <= rptr_q + PW'(1);
                    level_q <= level_d;
                    state_q <= state_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_pcg_rng_multi.sv
// Bench for wb_pcg_rng_multi: directed scenarios plus a randomized phase,
// all DATA words compared against a per-channel 64-bit LCG reference model.
module tb_wb_pcg_rng_multi;
    localparam int NCH = 2;
    localparam logic [63:0] SEED_RST = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] MULT_RST = 64'h5851_F42D_4C95_7F2D;
    localparam logic [63:0] INC_RST  = 64'h1405_7B7E_F767_814F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_w, dat_r;
    logic        sel, we, cyc, stb, ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_seed [NCH];
    logic [63:0] m_mult [NCH];
    logic [63:0] m_inc  [NCH];
    logic [63:0] m_st   [NCH];
    logic        m_mode [NCH];

    wb_pcg_rng_multi #(.CHANNELS(2), .FIFO_DEPTH(4), .MODE_DEFAULT(0)) dut (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
        .sel(sel), .we(we), .cyc(cyc), .stb(stb), .ack(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pcg_out(input logic [63:0] s, input logic m);
        logic [31:0] xv;
        int          r;
        if (!m) return s[31:0] ^ 32'(s >> 50);
        xv = 32'((s ^ (s >> 18)) >> 27);
        r  = int'(s >> 59);
        if (r == 0) return xv;
        return (xv >> r) | (xv << (32 - r));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_seed[c] = SEED_RST;
            m_mult[c] = MULT_RST;
            m_inc[c]  = INC_RST + 64'(2 * c);
            m_st[c]   = SEED_RST;
            m_mode[c] = 1'b0;
        end
    endtask

    task automatic next_word(input int c, output logic [31:0] w);
        w = pcg_out(m_st[c], m_mode[c]);
        m_st[c] = m_st[c] * m_mult[c] + m_inc[c];
    endtask

    function automatic logic [31:0] wa(input int c, input int r);
        return 32'((c << 3) | r);
    endfunction

    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd);
        @(negedge clk);
        adr = a; we = w; dat_w = d; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ack", {31'b0, ack}, 32'd1);
        rd = dat_r;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] junk;
        wb_xfer(a, 1'b1, d, junk);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_xfer(a, 1'b0, 32'd0, d);
    endtask

    task automatic read_data_chk(input int c, input string tag);
        logic [31:0] got, e;
        wb_read(wa(c, 0), got);
        next_word(c, e);
        check_eq(tag, got, e);
    endtask

    task automatic reseed(input int c, input logic [63:0] s, input logic m, input logic en);
        wb_write(wa(c, 1), s[63:32]);
        wb_write(wa(c, 2), s[31:0]);
        wb_write(wa(c, 7), {29'd0, 1'b1, m, en});
        m_seed[c] = s;
        m_st[c]   = s;
        m_mode[c] = m;
    endtask

    function automatic logic [31:0] cfg_word(input int c, input int r);
        case (r)
            1: return m_seed[c][63:32];
            2: return m_seed[c][31:0];
            3: return m_mult[c][63:32];
            4: return m_mult[c][31:0];
            5: return m_inc[c][63:32];
            default: return m_inc[c][31:0];
        endcase
    endfunction

    initial begin
        logic [31:0] got, e;
        int          acks;
        int          c, op, r;
        logic [63:0] s;

        rst = 1'b1; adr = '0; dat_w = '0; sel = 1'b1; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {31'b0, ack}, 32'd0);
        check_eq("rst_dat_r", dat_r, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset values of the configuration registers.
        for (int rr = 1; rr <= 6; rr++) begin
            wb_read(wa(0, rr), got);
            check_eq("rst_cfg_ch0", got, cfg_word(0, rr));
        end
        wb_read(wa(1, 6), got);
        check_eq("rst_inc_lo_ch1", got, 32'hF767_8151);
        wb_read(wa(0, 7), got);
        check_eq("rst_status", got, 32'h0001_0000);

        // Underflow on an empty disabled channel, then clear it.
        wb_read(wa(0, 0), got);
        check_eq("uflow_data", got, 32'd0);
        wb_read(wa(0, 7), got);
        check_eq("uflow_status", got, 32'h0005_0000);
        wb_write(wa(0, 7), 32'h8);
        wb_read(wa(0, 7), got);
        check_eq("uflow_clr_status", got, 32'h0001_0000);

        // First word after enabling from reset.
        wb_write(wa(0, 7), 32'h1);
        repeat (8) @(posedge clk);
        wb_read(wa(0, 0), got);
        next_word(0, e);
        check_eq("first_word", got, 32'h9ABC_DA7D);
        @(posedge clk);
        #1;
        check_eq("idle_ack", {31'b0, ack}, 32'd0);
        check_eq("idle_dat_r", dat_r, 32'd0);
        for (int i = 0; i < 3; i++) read_data_chk(0, "seq_ch0");

        // Left unread: full FIFO and frozen generator.
        repeat (20) @(posedge clk);
        wb_read(wa(0, 7), got);
        check_eq("full_status", got, 32'h0002_0401);
        for (int i = 0; i < 6; i++) read_data_chk(0, "after_full");

        // Mid-run reseed flushes and restarts from the new seed.
        reseed(0, 64'd1, 1'b0, 1'b1);
        wb_read(wa(0, 0), got);
        next_word(0, e);
        check_eq("reseed_word", got, 32'h0000_0001);
        wb_write(wa(0, 7), 32'h4);
        m_st[0] = m_seed[0];
        wb_read(wa(0, 7), got);
        check_eq("reseed_flush_status", got, 32'h0001_0000);

        // Held strobe: one ack, one pop; channel 1 independent.
        wb_write(wa(1, 7), 32'h1);
        wb_write(wa(0, 7), 32'h1);
        repeat (4) @(posedge clk);
        acks = 0; got = '0;
        @(negedge clk);
        adr = wa(0, 0); we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acks++;
                got = dat_r;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        check_eq("hold_acks", 32'(acks), 32'd1);
        next_word(0, e);
        check_eq("hold_data", got, e);
        for (int i = 0; i < 4; i++) begin
            read_data_chk(1, "interleave_ch1");
            read_data_chk(0, "interleave_ch0");
        end

        // Unmapped accesses and DATA writes have no side effect.
        wb_read(wa(2, 0), got);
        check_eq("bad_ch_read", got, 32'd0);
        wb_write(wa(2, 7), 32'h5);
        wb_read(32'h40, got);
        check_eq("bad_hi_read", got, 32'd0);
        wb_xfer(wa(0, 0), 1'b1, 32'hFFFF_FFFF, got);
        check_eq("data_write_dat_r", got, 32'd0);
        read_data_chk(0, "after_bad_ch0");
        read_data_chk(1, "after_bad_ch1");

        // XSH-RR output mode.
        reseed(0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) read_data_chk(0, "mode1_ch0");

        // Randomized traffic against the model.
        for (int i = 0; i < 200; i++) begin
            c  = int'($urandom_range(0, NCH - 1));
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                read_data_chk(c, "rand_data");
            end else if (op == 6) begin
                r = int'($urandom_range(1, 6));
                wb_read(wa(c, r), got);
                check_eq("rand_cfg", got, cfg_word(c, r));
            end else if (op == 7) begin
                wb_read(wa(c, 7), got);
                check_eq("rand_status", got & 32'h0004_0003, {30'd0, m_mode[c], 1'b1});
            end else begin
                if (op == 9) begin
                    s = {$urandom, $urandom} | 64'd1;
                    wb_write(wa(c, 3), s[63:32]);
                    wb_write(wa(c, 4), s[31:0]);
                    m_mult[c] = s;
                    s = {$urandom, $urandom};
                    wb_write(wa(c, 5), s[63:32]);
                    wb_write(wa(c, 6), s[31:0]);
                    m_inc[c] = s;
                end
                s = {$urandom, $urandom};
                reseed(c, s, 1'($urandom_range(0, 1)), 1'b1);
            end
        end

        // Reset asserted in the cycle after an accepted DATA read.
        @(negedge clk);
        adr = wa(0, 0); we = 1'b0; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_ack", {31'b0, ack}, 32'd0);
        check_eq("midrst_dat_r", dat_r, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wb_read(wa(0, 7), got);
        check_eq("midrst_status", got, 32'h0001_0000);
        for (int rr = 1; rr <= 6; rr++) begin
            wb_read(wa(1, rr), got);
            check_eq("midrst_cfg_ch1", got, cfg_word(1, rr));
        end
        wb_read(wa(0, 4), got);
        check_eq("midrst_mult_lo", got, 32'h4C95_7F2D);
        wb_write(wa(0, 7), 32'h1);
        repeat (8) @(posedge clk);
        wb_read(wa(0, 0), got);
        next_word(0, e);
        check_eq("midrst_first_word", got, 32'h9ABC_DA7D);
        read_data_chk(0, "midrst_seq");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
